// File: rtl/bvult_bvashr_ic_checker.sv
// bvult_bvashr_ic_checker
//
// Exhaustive checker for the invertibility condition of (x >>> s) <u t, where
// >>> is arithmetic shift right and x is the unknown. For each accepted request,
// every x in 0..2^W-1 is evaluated, one per cycle. The block then reports:
// whether a witness exists, the smallest witness, the number of satisfying x,
// and whether the closed form (t != 0) agrees with the sweep.
//
// Optional feature macro: BVIC_CANDIDATE_EN. When it is defined, the block also
// checks a candidate witness (for example, the output of a Skolem function)
// against the same predicate.
//
// Ports:
//   clk          clock; all logic on rising edge
//   rst          synchronous, active-high reset
//   in_valid     request valid
//   in_ready     request accepted (high in IDLE only)
//   s_in, t_in   shift amount / unsigned comparison bound (W bits)
//   out_valid    result valid (DONE state)
//   out_ready    consumer accepts result
//   ic_holds     at least one x satisfies the predicate
//   ic_expected  closed-form IC, (t != 0)
//   ic_mismatch  ic_holds ^ ic_expected
//   first_x      smallest satisfying x, 0 if none
//   sat_count    number of satisfying x (CW bits, holds 2^W)
//   cand_x       [BVIC_CANDIDATE_EN] candidate witness, latched on accept
//   cand_ok      [BVIC_CANDIDATE_EN] candidate satisfies the predicate
//   cand_bad     [BVIC_CANDIDATE_EN] a witness exists but the candidate fails

module bvult_bvashr_ic_checker #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = W + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  s_in,
  input  logic [W-1:0]  t_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          ic_holds,
  output logic          ic_expected,
  output logic          ic_mismatch,
  output logic [W-1:0]  first_x,
  output logic [CW-1:0] sat_count
`ifdef BVIC_CANDIDATE_EN
  ,
  input  logic [W-1:0]  cand_x,
  output logic          cand_ok,
  output logic          cand_bad
`endif
);

  localparam logic [W:0] WBound = (W + 1)'(W);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  // Predicate (x >>> s) <u t. A shift of W or more leaves only sign copies.
  function automatic logic pred(input logic [W-1:0] x, input logic [W-1:0] s,
                                input logic [W-1:0] t);
    logic [W-1:0] r;
    if ({1'b0, s} >= WBound) begin
      r = {W{x[W-1]}};
    end else begin
      r = $signed(x) >>> s;
    end
    return r < t;
  endfunction

  state_e        state_q, state_d;
  logic [W-1:0]  s_q, s_d, t_q, t_d, x_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          found_q, found_d;
  logic [W-1:0]  first_q, first_d;

  // Result registers, loaded only when the sweep completes.
  logic          holds_q, holds_d, expected_q, expected_d, mismatch_q, mismatch_d;
  logic [W-1:0]  first_out_q, first_out_d;
  logic [CW-1:0] count_out_q, count_out_d;

  logic          accept, finish, sat, found_next;
  logic [CW-1:0] cnt_next;
  logic [W-1:0]  first_next;

  assign accept = (state_q == StIdle) && in_valid;
  assign finish = (state_q == StSweep) && (x_q == {W{1'b1}});

  // Accumulator values including the x evaluated in the current cycle.
  assign sat        = pred(x_q, s_q, t_q);
  assign cnt_next   = sat ? cnt_q + CW'(1) : cnt_q;
  assign found_next = found_q | sat;
  assign first_next = (sat && !found_q) ? x_q : first_q;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    t_d         = t_q;
    x_d         = x_q;
    cnt_d       = cnt_q;
    found_d     = found_q;
    first_d     = first_q;
    holds_d     = holds_q;
    expected_d  = expected_q;
    mismatch_d  = mismatch_q;
    first_out_d = first_out_q;
    count_out_d = count_out_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          s_d     = s_in;
          t_d     = t_in;
          x_d     = '0;
          cnt_d   = '0;
          found_d = 1'b0;
          first_d = '0;
          state_d = StSweep;
        end
      end
      StSweep: begin
        x_d     = x_q + W'(1);
        cnt_d   = cnt_next;
        found_d = found_next;
        first_d = first_next;
        if (finish) begin
          state_d     = StDone;
          holds_d     = found_next;
          expected_d  = (t_q != '0);
          mismatch_d  = found_next ^ (t_q != '0);
          first_out_d = first_next;
          count_out_d = cnt_next;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      s_q         <= '0;
      t_q         <= '0;
      x_q         <= '0;
      cnt_q       <= '0;
      found_q     <= 1'b0;
      first_q     <= '0;
      holds_q     <= 1'b0;
      expected_q  <= 1'b0;
      mismatch_q  <= 1'b0;
      first_out_q <= '0;
      count_out_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      t_q         <= t_d;
      x_q         <= x_d;
      cnt_q       <= cnt_d;
      found_q     <= found_d;
      first_q     <= first_d;
      holds_q     <= holds_d;
      expected_q  <= expected_d;
      mismatch_q  <= mismatch_d;
      first_out_q <= first_out_d;
      count_out_q <= count_out_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign ic_holds    = holds_q;
  assign ic_expected = expected_q;
  assign ic_mismatch = mismatch_q;
  assign first_x     = first_out_q;
  assign sat_count   = count_out_q;

`ifdef BVIC_CANDIDATE_EN
  logic [W-1:0] cand_q;
  logic         cand_ok_q, cand_bad_q, cand_sat;

  assign cand_sat = pred(cand_q, s_q, t_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q     <= '0;
      cand_ok_q  <= 1'b0;
      cand_bad_q <= 1'b0;
    end else begin
      if (accept) begin
        cand_q <= cand_x;
      end
      if (finish) begin
        cand_ok_q  <= cand_sat;
        cand_bad_q <= found_next & ~cand_sat;
      end
    end
  end

  assign cand_ok  = cand_ok_q;
  assign cand_bad = cand_bad_q;
`endif

endmodule

// File: tb/tb_bvult_bvashr_ic_checker.sv
module tb_bvult_bvashr_ic_checker;

  localparam int W  = 4;
  localparam int CW = W + 1;
  localparam int N  = 1 << W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  s_in, t_in;
  logic          out_valid;
  logic          out_ready;
  logic          ic_holds, ic_expected, ic_mismatch;
  logic [W-1:0]  first_x;
  logic [CW-1:0] sat_count;
`ifdef BVIC_CANDIDATE_EN
  logic [W-1:0]  cand_x;
  logic          cand_ok, cand_bad;
`endif

  int checks = 0;
  int errors = 0;

  // Model expectations for the request in flight.
  int e_count, e_first, e_holds, e_expect, e_cand_ok;

  bvult_bvashr_ic_checker #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .s_in        (s_in),
    .t_in        (t_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ic_holds    (ic_holds),
    .ic_expected (ic_expected),
    .ic_mismatch (ic_mismatch),
    .first_x     (first_x),
    .sat_count   (sat_count)
`ifdef BVIC_CANDIDATE_EN
    ,
    .cand_x      (cand_x),
    .cand_ok     (cand_ok),
    .cand_bad    (cand_bad)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic shift right by plain integer arithmetic: shift, then OR in the
  // sign bits that a logical shift would have cleared.
  function automatic bit m_sat(input int x, input int s, input int t);
    int mask = N - 1;
    int sign = (x >> (W - 1)) & 1;
    int r;
    if (s >= W) r = sign ? mask : 0;
    else begin
      r = x >> s;
      if (sign != 0) r = r | (mask & ~(mask >> s));
    end
    return r < t;
  endfunction

  task automatic model(input int s, input int t, input int c);
    e_count = 0;
    e_first = -1;
    for (int x = 0; x < N; x++) begin
      if (m_sat(x, s, t)) begin
        e_count++;
        if (e_first < 0) e_first = x;
      end
    end
    e_holds   = (e_count > 0);
    if (e_first < 0) e_first = 0;
    e_expect  = (t != 0);
    e_cand_ok = m_sat(c, s, t);
  endtask

  // Compare process: every cycle a result is presented.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("sat_count", int'(sat_count), e_count);
      chk("first_x", int'(first_x), e_first);
      chk("ic_holds", int'(ic_holds), e_holds);
      chk("ic_expected", int'(ic_expected), e_expect);
      chk("ic_mismatch", int'(ic_mismatch), e_holds ^ e_expect);
      chk("in_ready in DONE", int'(in_ready), 0);
`ifdef BVIC_CANDIDATE_EN
      chk("cand_ok", int'(cand_ok), e_cand_ok);
      chk("cand_bad", int'(cand_bad), e_holds & ~e_cand_ok & 1);
`endif
    end
  end

  // Issue a request at a negedge, wait for the result, hold off the consumer
  // for 'hold' cycles, optionally poking in_valid while the result is held.
  task automatic run_req(input int s, input int t, input int c, input int hold,
                         input bit poke);
    int  n = 0;
    bit  seen = 0;
    model(s, t, c);
    chk("in_ready before accept", int'(in_ready), 1);
    in_valid  = 1'b1;
    s_in      = W'(s);
    t_in      = W'(t);
`ifdef BVIC_CANDIDATE_EN
    cand_x    = W'(c);
`endif
    out_ready = (hold == 0);
    while (n < 100 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      in_valid = 1'b0;
      s_in     = W'($urandom);
      t_in     = W'($urandom);
      if (out_valid) seen = 1;
      else if (n > 1) chk("in_ready during sweep", int'(in_ready), 0);
    end
    if (!seen) begin
      chk("out_valid timeout", 0, 1);
      return;
    end
    chk("latency", n, N + 1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (poke) begin
          in_valid = 1'b1;
          s_in     = W'($urandom);
          t_in     = W'($urandom);
        end
        @(negedge clk);
        chk("out_valid held", int'(out_valid), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid after handshake", int'(out_valid), 0);
    chk("in_ready after handshake", int'(in_ready), 1);
    if (poke) begin
      repeat (3) @(negedge clk);
      chk("no queued request", int'(in_ready), 1);
    end
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    s_in      = '0;
    t_in      = '0;
`ifdef BVIC_CANDIDATE_EN
    cand_x    = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset sat_count", int'(sat_count), 0);
    chk("reset ic_holds", int'(ic_holds), 0);
    chk("reset first_x", int'(first_x), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-computed literal expectations.
    run_req(3, 0, 0, 0, 0);
    chk("t0s3 count", int'(sat_count), 0);
    chk("t0s3 holds", int'(ic_holds), 0);
    chk("t0s3 mismatch", int'(ic_mismatch), 0);
    run_req(3, 8, 9, 0, 0);
    chk("t8s3 count", int'(sat_count), 8);
    chk("t8s3 first", int'(first_x), 0);
    chk("t8s3 holds", int'(ic_holds), 1);
`ifdef BVIC_CANDIDATE_EN
    chk("t8s3 c9 cand_ok", int'(cand_ok), 0);
    chk("t8s3 c9 cand_bad", int'(cand_bad), 1);
    run_req(3, 8, 7, 0, 0);
    chk("t8s3 c7 cand_ok", int'(cand_ok), 1);
    chk("t8s3 c7 cand_bad", int'(cand_bad), 0);
`endif
    run_req(1, 15, 0, 0, 0);
    chk("t15s1 count", int'(sat_count), 14);
    run_req(5, 15, 0, 0, 0);
    chk("t15s5 count", int'(sat_count), 8);
    run_req(0, 1, 0, 0, 0);
    chk("t1s0 count", int'(sat_count), 1);
    chk("t1s0 first", int'(first_x), 0);
    run_req(2, 13, 3, 0, 0);
    chk("t13s2 count", int'(sat_count), 8);

    // Backpressure with a rejected second request.
    run_req(1, 12, 12, 10, 1);

    // Abort mid-sweep.
    in_valid = 1'b1;
    s_in     = W'(3);
    t_in     = W'(8);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort sat_count", int'(sat_count), 0);
    chk("abort ic_holds", int'(ic_holds), 0);
    chk("abort ic_expected", int'(ic_expected), 0);
    chk("abort first_x", int'(first_x), 0);
    chk("abort in_ready", int'(in_ready), 1);
    seen = 0;
    repeat (2 * N) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("abort no result", seen, 0);

    // Randomized requests with random consumer stalls.
    for (int i = 0; i < 60; i++) begin
      run_req(int'($urandom_range(N - 1)), int'($urandom_range(N - 1)),
              int'($urandom_range(N - 1)), int'($urandom_range(3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
